// File: rtl/debounce_pkg.sv
// Shared types and default constants for the multi-channel debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int unsigned DEF_TICK_DIV     = 100000;
  localparam int unsigned DEF_STABLE_TICKS = 10;
  localparam int unsigned DEF_HOLD_TICKS   = 1000;

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-FF synchroniser, stability counter, 4-state FSM, edge pulses.
// Optional auto-repeat hold pulse when MULTI_DEBOUNCER_HOLD_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
`ifdef MULTI_DEBOUNCER_HOLD_EN
  ,
  parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sw,
  output logic debounced,
  output logic rise,
`ifdef MULTI_DEBOUNCER_HOLD_EN
  output logic hold,
`endif
  output logic fall
);

  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

  logic          r_s1, r_s2;
  db_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_deb, w_deb_nxt;
  logic          r_rise, w_rise_nxt;
  logic          r_fall, w_fall_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_deb   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1    <= sw;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_deb   <= w_deb_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // A revert of r_s2 is tested before tick so it wins when both coincide.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_deb_nxt   = r_deb;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (r_s2) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (tick) begin
          if (r_cnt == C_LAST) begin
            w_state_nxt = IDLE_HIGH;
            w_cnt_nxt   = '0;
            w_deb_nxt   = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      IDLE_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (r_s2) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (tick) begin
          if (r_cnt == C_LAST) begin
            w_state_nxt = IDLE_LOW;
            w_cnt_nxt   = '0;
            w_deb_nxt   = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign debounced = r_deb;
  assign rise      = r_rise;
  assign fall      = r_fall;

`ifdef MULTI_DEBOUNCER_HOLD_EN
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);

  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic          r_hold, w_hold_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_hold <= 1'b0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      r_hold <= w_hold_nxt;
    end
  end

  always_comb begin
    w_hcnt_nxt = '0;
    w_hold_nxt = 1'b0;
    if (r_state == IDLE_HIGH && w_state_nxt == IDLE_HIGH) begin
      w_hcnt_nxt = r_hcnt;
      if (tick) begin
        if (r_hcnt == H_LAST) begin
          w_hcnt_nxt = '0;
          w_hold_nxt = 1'b1;
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
    end
  end

  assign hold = r_hold;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// N-channel debouncer: shared sample-tick prescaler, per-channel debounce_channel, any_edge flag.
// Define MULTI_DEBOUNCER_HOLD_EN to add the HOLD_TICKS parameter and hold[] auto-repeat port.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH         = 9,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
`ifdef MULTI_DEBOUNCER_HOLD_EN
  ,
  parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
`ifdef MULTI_DEBOUNCER_HOLD_EN
  output logic [N_CH-1:0] hold,
`endif
  output logic            any_edge
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic          r_any_edge;

  assign w_tick = (r_presc == P_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_any_edge <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_any_edge <= |(rise | fall);
    end
  end

  assign any_edge = r_any_edge;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
`ifdef MULTI_DEBOUNCER_HOLD_EN
      ,
      .HOLD_TICKS  (HOLD_TICKS)
`endif
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (w_tick),
      .sw        (sw[g]),
      .debounced (debounced[g]),
      .rise      (rise[g]),
`ifdef MULTI_DEBOUNCER_HOLD_EN
      .hold      (hold[g]),
`endif
      .fall      (fall[g])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer (N_CH=4, TICK_DIV=4, STABLE_TICKS=3).
module tb_multi_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw = 4'h0;
  logic [3:0] debounced, rise, fall;
  logic       any_edge;
`ifdef MULTI_DEBOUNCER_HOLD_EN
  logic [3:0] hold;
`endif

  multi_debouncer #(
    .N_CH        (4),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
`ifdef MULTI_DEBOUNCER_HOLD_EN
    ,
    .HOLD_TICKS  (5)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .debounced(debounced),
    .rise     (rise),
    .fall     (fall),
`ifdef MULTI_DEBOUNCER_HOLD_EN
    .hold     (hold),
`endif
    .any_edge (any_edge)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_win(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: event at cycle %0d expected within [%0d,%0d]", nm, act, lo, hi);
    end
  endtask

  typedef struct {
    string      name;
    logic [3:0] deb;
    logic [3:0] rs;
    logic [3:0] fl;
    int         lo;
    int         hi;
  } exp_t;

  exp_t q[$];

  // Called #1 after an edge that left cyc==c: edge c+1 first samples sw,
  // and the flip lands 11..14 cycles after that sampling edge.
  task automatic expect_edge(input string nm, input logic [3:0] d, input logic [3:0] r,
                             input logic [3:0] f);
    exp_t e;
    e.name = nm;
    e.deb  = d;
    e.rs   = r;
    e.fl   = f;
    e.lo   = cyc + 12;
    e.hi   = cyc + 15;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per edge event; pulses must last one cycle
  // and any_edge must follow exactly one cycle later.
  bit pend = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("pulse_width", {24'h0, rise, fall}, 32'h0);
        chk("any_edge_after", {31'h0, any_edge}, 32'h1);
        pend = 1'b0;
      end else begin
        chk("any_edge_idle", {31'h0, any_edge}, 32'h0);
      end
      if ((rise | fall) != 4'h0) begin
        if (q.size() == 0) begin
          chk("unexpected_edge", {24'h0, rise, fall}, 32'h0);
        end else begin
          e = q.pop_front();
          chk({e.name, "_deb"}, {28'h0, debounced}, {28'h0, e.deb});
          chk({e.name, "_rise"}, {28'h0, rise}, {28'h0, e.rs});
          chk({e.name, "_fall"}, {28'h0, fall}, {28'h0, e.fl});
          chk_win({e.name, "_latency"}, cyc, e.lo, e.hi);
        end
        pend = 1'b1;
      end
    end
  end

`ifdef MULTI_DEBOUNCER_HOLD_EN
  int last_ref = -1;
  always @(negedge clk) begin
    if (reset) begin
      last_ref = -1;
    end else begin
      if (rise[0]) last_ref = cyc;
      if (hold[0]) begin
        chk("hold0_level", {31'h0, debounced[0]}, 32'h1);
        chk_win("hold0_period", (last_ref < 0) ? -1 : cyc - last_ref, 20, 20);
        last_ref = cyc;
      end
    end
  end
`endif

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_deb"}, {28'h0, debounced}, 32'h0);
    chk({nm, "_rise"}, {28'h0, rise}, 32'h0);
    chk({nm, "_fall"}, {28'h0, fall}, 32'h0);
    chk({nm, "_any"}, {31'h0, any_edge}, 32'h0);
  endtask

  initial begin
    // Reset held with all inputs high.
    sw = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_all_zero("in_reset");
    end
    step(1);
    reset = 1'b0;
    expect_edge("release_all_high", 4'hF, 4'hF, 4'h0);
    step(20);

    sw = 4'h0;
    expect_edge("all_low", 4'h0, 4'h0, 4'hF);
    step(20);

    sw[0] = 1'b1;
    expect_edge("ch0_rise", 4'h1, 4'h1, 4'h0);
    step(20);

    // Bouncing channel 1: 3-cycle plateaus are far shorter than the 8-cycle minimum.
    for (int i = 0; i < 20; i++) begin
      sw[1] = ~sw[1];
      step(3);
    end
    sw[1] = 1'b0;
    step(20);
    chk("bounce_rejected", {28'h0, debounced}, 32'h1);

    sw[2] = 1'b1;
    expect_edge("ch2_rise", 4'h5, 4'h4, 4'h0);
    step(20);
    sw[2] = 1'b0;
    expect_edge("ch2_fall", 4'h1, 4'h0, 4'h4);
    step(20);

    // Reset while ch3 sits in WAIT_HIGH with two ticks counted.
    sw[3] = 1'b1;
    step(11);
    reset = 1'b1;
    #1;
    chk_all_zero("mid_debounce_reset");
    step(3);
    reset = 1'b0;
    expect_edge("after_reset", 4'h9, 4'h9, 4'h0);
    step(20);

    chk("queue_drained", q.size(), 32'h0);
    chk("final_levels", {28'h0, debounced}, 32'h9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
